// File: rtl/cam_capture_win.sv
// rtl/cam_capture_win.sv - windowed, decimating camera capture engine; CAM_CAPTURE_STATS_EN enables frame count and line error
// Input registers -> beat assembly/window decision -> registered write strobe, address and data.
module cam_capture_win #(
  parameter int DATA_W     = 4,
  parameter int BEATS      = 2,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int DECIM_LOG2 = 0,
  parameter int ADDR_W     = 19,
  localparam int PIX_W     = DATA_W * BEATS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_single,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [DATA_W-1:0] i_d,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [PIX_W-1:0]  o_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt,
  output logic              o_line_err
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [15:0] H_LIM = 16'(H_ACT);
  localparam logic [15:0] V_LIM = 16'(V_ACT);
  localparam logic [15:0] DMASK = 16'((1 << DECIM_LOG2) - 1);
  localparam logic [15:0] SAT   = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

  state_t            state_q;
  logic              vs_q, hr_q, vs_p_q, hr_p_q;
  logic [DATA_W-1:0] d_q;
  logic [BW-1:0]     beat_q;
  logic [PIX_W-1:0]  sr_q, pix_q;
  logic              pend_q;
  logic [15:0]       x_q, y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, done_q;
  logic [ADDR_W-1:0] oaddr_q;
  logic [PIX_W-1:0]  odata_q;

  logic             vs_fall, vs_rise, hr_fall, in_win;
  logic [PIX_W-1:0] pix_d;

  assign vs_fall = vs_p_q & ~vs_q;
  assign vs_rise = ~vs_p_q & vs_q;
  assign hr_fall = hr_p_q & ~hr_q;
  assign pix_d   = (sr_q << DATA_W) | PIX_W'(d_q);
  assign in_win  = (x_q < H_LIM) && (y_q < V_LIM) &&
                   ((x_q & DMASK) == 16'd0) && ((y_q & DMASK) == 16'd0);

  assign o_we         = we_q;
  assign o_addr       = oaddr_q;
  assign o_data       = odata_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = done_q;

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic        line_err_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_line_err  = line_err_q;
`else
  assign o_frame_cnt = 16'd0;
  assign o_line_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      vs_p_q  <= 1'b0;
      hr_p_q  <= 1'b0;
      d_q     <= '0;
      beat_q  <= '0;
      sr_q    <= '0;
      pix_q   <= '0;
      pend_q  <= 1'b0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
`ifdef CAM_CAPTURE_STATS_EN
      frame_cnt_q <= 16'd0;
      line_err_q  <= 1'b0;
`endif
    end else begin
      vs_q   <= i_vsync;
      hr_q   <= i_href;
      d_q    <= i_d;
      vs_p_q <= vs_q;
      hr_p_q <= hr_q;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;

      // A pixel accepted last cycle is dropped if capture was disarmed meanwhile.
      if (pend_q && i_enable) begin
        we_q    <= 1'b1;
        oaddr_q <= addr_q;
        odata_q <= pix_q;
        addr_q  <= addr_q + ADDR_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (i_enable) state_q <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!i_enable) begin
            state_q <= IDLE;
          end else if (vs_fall) begin
            state_q <= ACTIVE;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            addr_q  <= '0;
            oaddr_q <= '0;
            beat_q  <= '0;
`ifdef CAM_CAPTURE_STATS_EN
            line_err_q <= 1'b0;
`endif
          end
        end
        ACTIVE: begin
          if (!i_enable) begin
            state_q <= IDLE;
          end else begin
            if (hr_q) begin
              sr_q <= pix_d;
              if (beat_q == BEAT_LAST) begin
                beat_q <= '0;
                if (x_q != SAT) x_q <= x_q + 16'd1;
                if (in_win) begin
                  pend_q <= 1'b1;
                  pix_q  <= pix_d;
                end
              end else begin
                beat_q <= beat_q + BW'(1);
              end
            end
            // Line end is handled in the same cycle as a coincident frame end.
            if (hr_fall) begin
              beat_q <= '0;
              x_q    <= 16'd0;
              if (x_q != 16'd0 && y_q != SAT) y_q <= y_q + 16'd1;
`ifdef CAM_CAPTURE_STATS_EN
              if (x_q != H_LIM) line_err_q <= 1'b1;
`endif
            end
            if (vs_rise) state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
`ifdef CAM_CAPTURE_STATS_EN
          frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
          state_q <= (i_enable && !i_single) ? WAIT_SOF : IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_win.sv
// tb/tb_cam_capture_win.sv - directed/random bench for cam_capture_win against a frame-level model
module tb_cam_capture_win;

  localparam int DW = 4;
  localparam int BEATS = 2;
`ifdef CAM_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, single, vs, hr;
  logic [DW-1:0] d;

  logic       o_we_a, o_busy_a, o_frame_done_a, o_line_err_a;
  logic [3:0] o_addr_a;
  logic [7:0] o_data_a;
  logic [15:0] o_frame_cnt_a;
  logic       o_we_b, o_busy_b, o_frame_done_b, o_line_err_b;
  logic [3:0] o_addr_b;
  logic [7:0] o_data_b;
  logic [15:0] o_frame_cnt_b;

  always #5 clk = ~clk;

  cam_capture_win #(.DATA_W(DW), .BEATS(BEATS), .H_ACT(4), .V_ACT(2), .DECIM_LOG2(0), .ADDR_W(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_single(single), .i_vsync(vs), .i_href(hr), .i_d(d),
    .o_we(o_we_a), .o_addr(o_addr_a), .o_data(o_data_a), .o_busy(o_busy_a),
    .o_frame_done(o_frame_done_a), .o_frame_cnt(o_frame_cnt_a), .o_line_err(o_line_err_a));

  cam_capture_win #(.DATA_W(DW), .BEATS(BEATS), .H_ACT(8), .V_ACT(4), .DECIM_LOG2(1), .ADDR_W(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_single(single), .i_vsync(vs), .i_href(hr), .i_d(d),
    .o_we(o_we_b), .o_addr(o_addr_b), .o_data(o_data_b), .o_busy(o_busy_b),
    .o_frame_done(o_frame_done_b), .o_frame_cnt(o_frame_cnt_b), .o_line_err(o_line_err_b));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cap_a[$];
  int cap_b[$];
  int exp_a[$];
  int exp_b[$];
  int line_len[$];
  int beats[$];
  bit le_a, le_b;
  int first_we_a = -1;
  int last_we_a = -1;
  int lat_edge = -1;
  int dn_a = 0;
  int dn_b = 0;
  int exp_dn = 0;
  int exp_fc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_we_a) begin
      cap_a.push_back(int'({o_addr_a, o_data_a}));
      if (first_we_a < 0) first_we_a = cyc;
      if (last_we_a >= 0) chk("spacing_a", 64'(cyc - last_we_a >= BEATS), 64'd1);
      last_we_a = cyc;
    end
    if (o_we_b) cap_b.push_back(int'({o_addr_b, o_data_b}));
    if (o_frame_done_a) dn_a++;
    if (o_frame_done_b) dn_b++;
  end

  // Frame-level model: pixels per line, window, decimation, sequential addresses.
  task automatic build(input int h, input int v, input int dl, input bit sel);
    int y, addr, pos, np, step, e;
    bit err;
    step = 1 << dl; y = 0; addr = 0; pos = 0; err = 0;
    if (sel) exp_b.delete(); else exp_a.delete();
    foreach (line_len[i]) begin
      np = line_len[i] / BEATS;
      for (int p = 0; p < np; p++) begin
        if (p < h && y < v && p % step == 0 && y % step == 0) begin
          e = addr * 256 + beats[pos + 2 * p] * 16 + beats[pos + 2 * p + 1];
          if (sel) exp_b.push_back(e); else exp_a.push_back(e);
          addr++;
        end
      end
      if (np != h) err = 1;
      if (np > 0) y++;
      pos += line_len[i];
    end
    if (sel) le_b = err; else le_a = err;
  endtask

  task automatic frame_begin();
    vs = 1'b1; hr = 1'b0;
    repeat (4) tick();
    line_len.delete(); beats.delete();
    cap_a.delete(); cap_b.delete();
    first_we_a = -1; lat_edge = -1;
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nbeats, input bit ab);
    int v;
    hr = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      v = ab ? ((b % 2) ? 'hB : 'hA) : int'($urandom_range(15));
      d = DW'(v);
      beats.push_back(v);
      if (b == BEATS - 1 && lat_edge < 0) lat_edge = cyc + 1;
      tick();
    end
    hr = 1'b0; d = '0;
    line_len.push_back(nbeats);
    repeat (3) tick();
  endtask

  task automatic frame_end();
    int vs_edge, dcyc;
    bit got;
    vs = 1'b1; vs_edge = cyc + 1; got = 0; dcyc = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_frame_done_a) begin got = 1; dcyc = cyc; break; end
    end
    exp_dn++;
    exp_fc = (exp_fc + 1) & 'hFFFF;
    chk("done_seen", 64'(got), 64'd1);
    chk("done_latency", 64'(dcyc - vs_edge), 64'd2);
    chk("busy_at_done", 64'(o_busy_a), 64'(!single));
    chk("fcnt", 64'(o_frame_cnt_a), STATS ? 64'(exp_fc) : 64'd0);
    chk("we_latency", 64'(first_we_a - lat_edge), 64'd2);
    repeat (2) tick();
    build(4, 2, 0, 0);
    build(8, 4, 1, 1);
    chk("wcnt_a", 64'(cap_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      chk("wr_a", 64'(i < cap_a.size() ? cap_a[i] : -1), 64'(exp_a[i]));
    chk("wcnt_b", 64'(cap_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++)
      chk("wr_b", 64'(i < cap_b.size() ? cap_b[i] : -1), 64'(exp_b[i]));
    chk("lerr_a", 64'(o_line_err_a), STATS ? 64'(le_a) : 64'd0);
    chk("lerr_b", 64'(o_line_err_b), STATS ? 64'(le_b) : 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 64'(o_we_a), 64'd0);
    chk({tag, "_addr"}, 64'(o_addr_a), 64'd0);
    chk({tag, "_data"}, 64'(o_data_a), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy_a), 64'd0);
    chk({tag, "_done"}, 64'(o_frame_done_a), 64'd0);
    chk({tag, "_fcnt"}, 64'(o_frame_cnt_a), 64'd0);
    chk({tag, "_lerr"}, 64'(o_line_err_a), 64'd0);
    chk({tag, "_busy_b"}, 64'(o_busy_b), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int drop_edge;
    bit got;
    rst = 1'b1; en = 1'b0; single = 1'b0; vs = 1'b1; hr = 1'b0; d = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // single-shot frame, fixed A/B beats
    en = 1'b1; single = 1'b1;
    frame_begin();
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    frame_end();
    for (int i = 0; i < 8; i++)
      chk("single_ab", 64'(i < cap_a.size() ? cap_a[i] : -1), 64'(i * 256 + 'hAB));
    en = 1'b0;
    repeat (2) tick();
    chk("busy_after_single", 64'(o_busy_a), 64'd0);

    rst = 1'b1; tick(); rst = 1'b0; exp_fc = 0;
    chk("fcnt_after_rst", 64'(o_frame_cnt_a), 64'd0);

    // continuous mode
    single = 1'b0; en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame_begin();
      send_line(8, 1'b0);
      send_line(8, 1'b0);
      frame_end();
    end
    chk("fcnt3", 64'(o_frame_cnt_a), STATS ? 64'd3 : 64'd0);

    // long line, then short line, then clean frame
    frame_begin(); send_line(10, 1'b0); send_line(8, 1'b0); frame_end();
    repeat (5) tick();
    chk("lerr_sticky", 64'(o_line_err_a), STATS ? 64'd1 : 64'd0);
    frame_begin(); send_line(8, 1'b0); send_line(6, 1'b0); frame_end();
    frame_begin(); send_line(8, 1'b0); send_line(8, 1'b0); frame_end();

    // partial pixels at line ends
    frame_begin(); send_line(1, 1'b0); send_line(8, 1'b0); send_line(7, 1'b0); frame_end();

    // full frame for the decimating instance
    frame_begin();
    for (int l = 0; l < 4; l++) send_line(16, 1'b0);
    frame_end();
    chk("decim_cnt", 64'(cap_b.size()), 64'd8);

    // reset mid-line
    frame_begin();
    send_line(8, 1'b0);
    hr = 1'b1;
    for (int b = 0; b < 3; b++) begin d = DW'($urandom_range(15)); tick(); end
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    rst = 1'b0; exp_fc = 0;
    cap_a.delete(); cap_b.delete();
    for (int b = 0; b < 3; b++) begin d = DW'($urandom_range(15)); tick(); end
    hr = 1'b0;
    repeat (3) tick();
    send_line(8, 1'b0);
    vs = 1'b1; got = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (o_frame_done_a) got = 1; end
    chk("no_done_after_rst", 64'(got), 64'd0);
    chk("no_wr_after_rst", 64'(cap_a.size() + cap_b.size()), 64'd0);
    frame_begin(); send_line(8, 1'b0); send_line(8, 1'b0); frame_end();

    // enable dropped mid-frame
    frame_begin();
    send_line(8, 1'b0);
    cap_a.delete(); cap_b.delete();
    hr = 1'b1;
    for (int b = 0; b < 2; b++) begin d = DW'($urandom_range(15)); tick(); end
    en = 1'b0; drop_edge = cyc + 1;
    for (int b = 0; b < 3; b++) begin d = DW'($urandom_range(15)); tick(); end
    chk("busy_after_drop", 64'(o_busy_a), 64'd0);
    chk("we_after_drop", 64'(o_we_a), 64'd0);
    chk("last_we_before_drop", 64'(last_we_a < drop_edge), 64'd1);
    en = 1'b1;
    for (int b = 0; b < 3; b++) begin d = DW'($urandom_range(15)); tick(); end
    hr = 1'b0;
    repeat (3) tick();
    send_line(8, 1'b0);
    vs = 1'b1; got = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (o_frame_done_a) got = 1; end
    chk("no_done_after_drop", 64'(got), 64'd0);
    chk("no_wr_after_drop", 64'(cap_a.size() + cap_b.size()), 64'd0);
    frame_begin(); send_line(8, 1'b0); send_line(8, 1'b0); frame_end();

    chk("done_count_a", 64'(dn_a), 64'(exp_dn));
    chk("done_count_b", 64'(dn_b), 64'(exp_dn));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
